comp_arb_share: RTL and testbench

COMP_ARB_SHARE -- requirements
Module: comp_arb_share

---
 rtl/comp_arb_share_pkg.sv | 14 +
 rtl/comp_arb_share_core.sv | 18 +
 rtl/comp_arb_share.sv | 131 +++++++++++++
 tb/tb_comp_arb_share.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_arb_share_pkg.sv
// Shared types and constants for the comp_arb_share arbitrated comparator.
package comp_arb_share_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/comp_arb_share_core.sv
// comp_core: combinational unsigned magnitude comparator shared by both requesters.
module comp_core
  import comp_arb_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gr,
  output logic             eq
);

  assign lt = (a < b);
  assign gr = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/comp_arb_share.sv
// Two-requester arbiter in front of a single time-shared comparator.
// Define COMP_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module comp_arb_share
  import comp_arb_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ack,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ack,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_lt,
  output logic             rsp_gr,
  output logic             rsp_eq,
  output logic             busy
);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b;
  req_id_t          op_id;
  req_id_t          winner;
  logic             grant;
  logic             core_lt, core_gr, core_eq;
  logic             lt_q, gr_q, eq_q;
  req_id_t          rsp_id_q;

`ifdef COMP_ARB_RR_EN
  req_id_t rr_ptr;
`endif

  // Winner selection only matters on a tie; a lone requester always wins.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef COMP_ARB_RR_EN
      winner = rr_ptr;
`else
      winner = 1'b0;
`endif
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  assign grant = (state == IDLE) && (req0_valid || req1_valid);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = CMP;
      CMP:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operands are captured once per transaction; the flags are only loaded at
  // the end of CMP and cleared otherwise, so they read zero outside RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= 1'b0;
      lt_q     <= 1'b0;
      gr_q     <= 1'b0;
      eq_q     <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      if (grant) begin
        op_a  <= winner ? req1_a : req0_a;
        op_b  <= winner ? req1_b : req0_b;
        op_id <= winner;
      end
      if (state == CMP) begin
        lt_q     <= core_lt;
        gr_q     <= core_gr;
        eq_q     <= core_eq;
        rsp_id_q <= op_id;
      end else begin
        lt_q <= 1'b0;
        gr_q <= 1'b0;
        eq_q <= 1'b0;
      end
    end
  end

`ifdef COMP_ARB_RR_EN
  // After serving a requester, prefer the other one on the next tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (state == RESP) begin
      rr_ptr <= ~rsp_id_q;
    end
  end
`endif

  comp_core #(.WIDTH(WIDTH)) u_core (
    .a  (op_a),
    .b  (op_b),
    .lt (core_lt),
    .gr (core_gr),
    .eq (core_eq)
  );

  assign req0_ack  = (state == CMP) && (op_id == 1'b0);
  assign req1_ack  = (state == CMP) && (op_id == 1'b1);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_lt    = lt_q;
  assign rsp_gr    = gr_q;
  assign rsp_eq    = eq_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_comp_arb_share.sv
// Scoreboard bench for comp_arb_share: a cycle model predicts acks/busy and pushes
// expected results; DUT responses pop and compare. Honours COMP_ARB_RR_EN.
module tb_comp_arb_share;
  import comp_arb_share_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  typedef struct packed {
    logic id;
    logic lt;
    logic gr;
    logic eq;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ack, req1_ack;
  logic         rsp_valid, rsp_id, rsp_lt, rsp_gr, rsp_eq, busy;

  pair_t  q0[$];
  pair_t  q1[$];
  exp_t   sb_q[$];
  logic   id_log[$];
  int     vectors = 0;
  int     miscompares = 0;

  state_t m_state;
  logic   m_cur_id, m_rsp_id;
`ifdef COMP_ARB_RR_EN
  logic   m_ptr;
`endif

  comp_arb_share #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ack   (req1_ack),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_lt     (rsp_lt),
    .rsp_gr     (rsp_gr),
    .rsp_eq     (rsp_eq),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_pair(input int which, input int a, input int b);
    pair_t p;
    p.a = W'(a);
    p.b = W'(b);
    if (which == 0) q0.push_back(p);
    else q1.push_back(p);
  endtask

  task automatic drive_inputs();
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    req0_a = req0_valid ? q0[0].a : '0;
    req0_b = req0_valid ? q0[0].b : '0;
    req1_a = req1_valid ? q1[0].a : '0;
    req1_b = req1_valid ? q1[0].b : '0;
  endtask

  // Model advances on the rising edge from the inputs the DUT sampled.
  task automatic model_edge();
    logic       win;
    exp_t       e;
    logic [W-1:0] a, b;
    if (!rst_n) begin
      m_state  = IDLE;
      m_cur_id = 1'b0;
      m_rsp_id = 1'b0;
`ifdef COMP_ARB_RR_EN
      m_ptr    = 1'b0;
`endif
      sb_q.delete();
    end else begin
      case (m_state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            if (req0_valid && req1_valid) begin
`ifdef COMP_ARB_RR_EN
              win = m_ptr;
`else
              win = 1'b0;
`endif
            end else begin
              win = req1_valid;
            end
            a = win ? req1_a : req0_a;
            b = win ? req1_b : req0_b;
            e.id = win;
            e.lt = (a < b);
            e.gr = (a > b);
            e.eq = (a == b);
            sb_q.push_back(e);
            m_cur_id = win;
            m_state  = CMP;
          end
        end
        CMP: begin
          m_rsp_id = m_cur_id;
          m_state  = RESP;
        end
        default: begin
`ifdef COMP_ARB_RR_EN
          m_ptr = ~m_rsp_id;
`endif
          m_state = IDLE;
        end
      endcase
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checkOutput("busy", 32'(busy), 32'(m_state != IDLE));
    checkOutput("req0_ack", 32'(req0_ack), 32'(m_state == CMP && m_cur_id == 1'b0));
    checkOutput("req1_ack", 32'(req1_ack), 32'(m_state == CMP && m_cur_id == 1'b1));
    checkOutput("ack_onehot", 32'(req0_ack & req1_ack), 32'd0);
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_state == RESP));
    if (rsp_valid) begin
      id_log.push_back(rsp_id);
      checkOutput("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
        checkOutput("rsp_flags", 32'({rsp_lt, rsp_gr, rsp_eq}), 32'({e.lt, e.gr, e.eq}));
        checkOutput("flags_onehot", 32'($countones({rsp_lt, rsp_gr, rsp_eq})), 32'd1);
      end
    end else begin
      checkOutput("flags_idle", 32'({rsp_lt, rsp_gr, rsp_eq}), 32'd0);
      checkOutput("rsp_id_hold", 32'(rsp_id), 32'(m_rsp_id));
    end
    if (req0_ack && q0.size() > 0) q0.delete(0);
    if (req1_ack && q1.size() > 0) q1.delete(0);
    drive_inputs();
  endtask

  task automatic applyStimulus(input int max_cycles);
    int n;
    n = 0;
    drive_inputs();
    while ((q0.size() > 0 || q1.size() > 0 || m_state != IDLE) && n < max_cycles) begin
      step();
      n++;
    end
    checkOutput("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    m_state = IDLE;
    m_cur_id = 1'b0;
    m_rsp_id = 1'b0;
`ifdef COMP_ARB_RR_EN
    m_ptr = 1'b0;
`endif
    drive_inputs();
    step();
    step();
    checkOutput("reset_outputs",
                32'({req0_ack, req1_ack, rsp_valid, rsp_id, rsp_lt, rsp_gr, rsp_eq, busy}), 32'd0);
    rst_n = 1'b1;
    step();

    // Single requesters, then unsigned boundary operands.
    push_pair(0, 5, 7);
    applyStimulus(20);
    push_pair(1, 10, 7);
    push_pair(1, 10, 10);
    applyStimulus(30);
    push_pair(0, 0, 15);
    push_pair(0, 15, 0);
    push_pair(1, 15, 15);
    push_pair(1, 0, 0);
    applyStimulus(40);

    // Both requesters held valid: order depends on arbitration mode.
    id_log.delete();
    for (int i = 0; i < 4; i++) begin
      push_pair(0, 3, 3);
      push_pair(1, 15, 0);
    end
    applyStimulus(60);
    checkOutput("tie_count", 32'(id_log.size()), 32'd8);
    if (id_log.size() >= 2) begin
      checkOutput("tie_first_id", 32'(id_log[0]), 32'd0);
`ifdef COMP_ARB_RR_EN
      checkOutput("tie_second_id", 32'(id_log[1]), 32'd1);
`else
      checkOutput("tie_second_id", 32'(id_log[1]), 32'd0);
`endif
    end

    // Reset during CMP aborts the pending pair.
    push_pair(0, 5, 7);
    drive_inputs();
    n = 0;
    while (!req0_ack && n < 10) begin
      step();
      n++;
    end
    checkOutput("abort_ack_seen", 32'(req0_ack), 32'd1);
    rst_n = 1'b0;
    step();
    checkOutput("abort_outputs",
                32'({req0_ack, req1_ack, rsp_valid, rsp_id, rsp_lt, rsp_gr, rsp_eq, busy}), 32'd0);
    rst_n = 1'b1;
    push_pair(0, 5, 7);
    applyStimulus(20);

    // Random traffic on both requesters.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      push_pair(i % 2, int'(ra), int'(rb));
      if ($urandom_range(0, 1) == 1) push_pair(1 - (i % 2), int'(rb), int'(ra));
    end
    applyStimulus(200);

    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
